scr1_pipe_lsu_ot: RTL and testbench

Pipelined load/store unit for the SCR1 pipeline that keeps up to OT_DEPTH data-memory transactions in flight instead of blocking on each response. It sits between the EXU and the DMEM router, in the same place as the single-outstanding LSU. Requests are issued combinationally and responses are returned to the EXU in order. A bus error flushes the responses still in flight.

---
 rtl/scr1_pipe_lsu_ot.sv | 210 +++++++++++++++++++++
 tb/tb_scr1_pipe_lsu_ot.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_pipe_lsu_ot.sv
// scr1_pipe_lsu_ot: load/store unit with up to OT_DEPTH outstanding DMEM transactions.
// Requests issue combinationally; responses return to the EXU in order through a small
// queue of {cmd, addr[1:0]} records. A bus error with more entries in flight drains them.
// Optional feature macro: SCR1_LSU_DATA_ALIGN_EN (byte-lane extraction of load data).
module scr1_pipe_lsu_ot #(
  parameter int unsigned OT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exu2lsu_req_i,
  input  logic [3:0]  exu2lsu_cmd_i,
  input  logic [31:0] exu2lsu_addr_i,
  input  logic [31:0] exu2lsu_sdata_i,
  output logic        lsu2exu_req_ack_o,
  output logic        lsu2exu_rdy_o,
  output logic [31:0] lsu2exu_ldata_o,
  output logic        lsu2exu_exc_o,
  output logic [3:0]  lsu2exu_exc_code_o,
  output logic        lsu2exu_busy_o,
  output logic [34:0] lsu2tdu_dmon_o,
  input  logic        tdu2lsu_ibrkpt_exc_req_i,
  input  logic        tdu2lsu_dbrkpt_exc_req_i,
  output logic        lsu2dmem_req_o,
  output logic        lsu2dmem_cmd_o,
  output logic [1:0]  lsu2dmem_width_o,
  output logic [31:0] lsu2dmem_addr_o,
  output logic [31:0] lsu2dmem_wdata_o,
  input  logic        dmem2lsu_req_ack_i,
  input  logic [31:0] dmem2lsu_rdata_i,
  input  logic [1:0]  dmem2lsu_resp_i
);

  localparam int unsigned PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OT_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OT_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(OT_DEPTH - 1);

  localparam logic [3:0] CMD_LB  = 4'd1;
  localparam logic [3:0] CMD_LH  = 4'd2;
  localparam logic [3:0] CMD_LW  = 4'd3;
  localparam logic [3:0] CMD_LBU = 4'd4;
  localparam logic [3:0] CMD_LHU = 4'd5;
  localparam logic [3:0] CMD_SB  = 4'd6;
  localparam logic [3:0] CMD_SH  = 4'd7;
  localparam logic [3:0] CMD_SW  = 4'd8;

  localparam logic [3:0] EXC_BRKPT    = 4'd3;
  localparam logic [3:0] EXC_LD_MISAL = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT = 4'd5;
  localparam logic [3:0] EXC_ST_MISAL = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT = 4'd7;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    ptr_inc = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
  endfunction

  // State
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             drain_q, drain_d;
  logic [3:0]       q_cmd [OT_DEPTH];
`ifdef SCR1_LSU_DATA_ALIGN_EN
  logic [1:0]       q_addr [OT_DEPTH];
`endif

  // Request decode
  logic       is_load, is_store, is_half, is_word;
  logic [1:0] req_width;
  logic       misalign, brkpt, imm_exc, imm_report;
  logic       q_empty, not_full, push, pop, resp_err;
  logic [3:0] head_cmd;
  logic [31:0] lane_data, ext_data;

  // Decode the incoming command into direction, access width and alignment class
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    req_width = 2'b10;
    case (exu2lsu_cmd_i)
      CMD_LB, CMD_LBU: begin is_load  = 1'b1; req_width = 2'b00; end
      CMD_LH, CMD_LHU: begin is_load  = 1'b1; req_width = 2'b01; is_half = 1'b1; end
      CMD_LW:          begin is_load  = 1'b1; is_word = 1'b1; end
      CMD_SB:          begin is_store = 1'b1; req_width = 2'b00; end
      CMD_SH:          begin is_store = 1'b1; req_width = 2'b01; is_half = 1'b1; end
      CMD_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      default:         ;
    endcase
  end

  assign misalign = (is_half & exu2lsu_addr_i[0]) | (is_word & (|exu2lsu_addr_i[1:0]));
  assign brkpt    = tdu2lsu_ibrkpt_exc_req_i | tdu2lsu_dbrkpt_exc_req_i;
  assign imm_exc  = exu2lsu_req_i & (misalign | brkpt);

  assign q_empty  = (count_q == '0);
  assign not_full = (count_q < DEPTH_C);
  // Immediate exceptions wait for an empty, non-draining queue to keep ordering precise
  assign imm_report = imm_exc & q_empty & ~drain_q;

  assign lsu2dmem_req_o   = exu2lsu_req_i & ~imm_exc & ~drain_q & not_full;
  assign lsu2dmem_cmd_o   = is_store;
  assign lsu2dmem_width_o = req_width;
  assign lsu2dmem_addr_o  = exu2lsu_addr_i;
  assign lsu2dmem_wdata_o = exu2lsu_sdata_i;

  assign push     = lsu2dmem_req_o & dmem2lsu_req_ack_i;
  assign pop      = (dmem2lsu_resp_i != 2'b00) & ~q_empty;
  assign resp_err = dmem2lsu_resp_i[1];

  assign lsu2exu_req_ack_o = push | imm_report;
  assign lsu2exu_rdy_o     = pop & ~drain_q;
  assign lsu2exu_busy_o    = ~q_empty | drain_q;

  assign lsu2tdu_dmon_o = {exu2lsu_req_i & not_full & ~drain_q & ~tdu2lsu_ibrkpt_exc_req_i,
                           is_load, is_store, exu2lsu_addr_i};

  assign head_cmd = q_cmd[rd_ptr_q];

  // Exception reporting: response error outranks immediate exceptions
  always_comb begin
    lsu2exu_exc_o      = 1'b0;
    lsu2exu_exc_code_o = 4'd0;
    if (lsu2exu_rdy_o & resp_err) begin
      lsu2exu_exc_o      = 1'b1;
      lsu2exu_exc_code_o = (head_cmd >= CMD_SB) ? EXC_ST_FAULT : EXC_LD_FAULT;
    end else if (imm_report) begin
      lsu2exu_exc_o = 1'b1;
      if (brkpt) begin
        lsu2exu_exc_code_o = EXC_BRKPT;
      end else if (is_load) begin
        lsu2exu_exc_code_o = EXC_LD_MISAL;
      end else begin
        lsu2exu_exc_code_o = EXC_ST_MISAL;
      end
    end
  end

`ifdef SCR1_LSU_DATA_ALIGN_EN
  assign lane_data = dmem2lsu_rdata_i >> {q_addr[rd_ptr_q], 3'b000};
`else
  assign lane_data = dmem2lsu_rdata_i;
`endif

  // Extend load data according to the head entry's command
  always_comb begin
    ext_data = dmem2lsu_rdata_i;
    case (head_cmd)
      CMD_LB:  ext_data = {{24{lane_data[7]}}, lane_data[7:0]};
      CMD_LBU: ext_data = {24'd0, lane_data[7:0]};
      CMD_LH:  ext_data = {{16{lane_data[15]}}, lane_data[15:0]};
      CMD_LHU: ext_data = {16'd0, lane_data[15:0]};
      default: ;
    endcase
    lsu2exu_ldata_o = lsu2exu_rdy_o ? ext_data : 32'd0;
  end

  // Next-state for count, pointers and drain flag
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
    drain_d = drain_q;
    if (pop & resp_err & ~drain_q & (count_q > CNT_W'(1))) begin
      drain_d = 1'b1;
    end
    if (pop & (count_d == '0)) begin
      drain_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drain_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drain_q  <= drain_d;
    end
  end

  // Response queue storage, written on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OT_DEPTH; i++) begin
        q_cmd[i] <= 4'd0;
`ifdef SCR1_LSU_DATA_ALIGN_EN
        q_addr[i] <= 2'd0;
`endif
      end
    end else if (push) begin
      q_cmd[wr_ptr_q] <= exu2lsu_cmd_i;
`ifdef SCR1_LSU_DATA_ALIGN_EN
      q_addr[wr_ptr_q] <= exu2lsu_addr_i[1:0];
`endif
    end
  end

endmodule

// File: tb/tb_scr1_pipe_lsu_ot.sv
// Self-checking bench for scr1_pipe_lsu_ot (OT_DEPTH=2): a table of single-cycle vectors
// from an empty queue, then hand-written multi-cycle sequences.
module tb_scr1_pipe_lsu_ot;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        req_ack, rdy, exc, busy;
  logic [31:0] ldata;
  logic [3:0]  exc_code;
  logic [34:0] dmon;
  logic        ibrk, dbrk;
  logic        dreq, dcmd;
  logic [1:0]  dwidth;
  logic [31:0] daddr, dwdata;
  logic        dack;
  logic [31:0] rdata;
  logic [1:0]  resp;

  int checks = 0;
  int errors = 0;

  scr1_pipe_lsu_ot #(.OT_DEPTH(2)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .exu2lsu_req_i            (req),
    .exu2lsu_cmd_i            (cmd),
    .exu2lsu_addr_i           (addr),
    .exu2lsu_sdata_i          (sdata),
    .lsu2exu_req_ack_o        (req_ack),
    .lsu2exu_rdy_o            (rdy),
    .lsu2exu_ldata_o          (ldata),
    .lsu2exu_exc_o            (exc),
    .lsu2exu_exc_code_o       (exc_code),
    .lsu2exu_busy_o           (busy),
    .lsu2tdu_dmon_o           (dmon),
    .tdu2lsu_ibrkpt_exc_req_i (ibrk),
    .tdu2lsu_dbrkpt_exc_req_i (dbrk),
    .lsu2dmem_req_o           (dreq),
    .lsu2dmem_cmd_o           (dcmd),
    .lsu2dmem_width_o         (dwidth),
    .lsu2dmem_addr_o          (daddr),
    .lsu2dmem_wdata_o         (dwdata),
    .dmem2lsu_req_ack_i       (dack),
    .dmem2lsu_rdata_i         (rdata),
    .dmem2lsu_resp_i          (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic        ibrk;
    logic        dbrk;
    logic        e_ack;
    logic        e_dreq;
    logic        e_dcmd;
    logic [1:0]  e_width;
    logic        e_exc;
    logic [3:0]  e_code;
    logic [2:0]  e_dmon;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [3:0] c, input logic [31:0] a,
                     input logic ak, input logic [1:0] rs, input logic [31:0] rd);
    req   = r;
    cmd   = c;
    addr  = a;
    dack  = ak;
    resp  = rs;
    rdata = rd;
    ibrk  = 1'b0;
    dbrk  = 1'b0;
  endtask

  initial begin
    // req cmd addr ibrk dbrk | ack dreq dcmd width exc code dmon[34:32]
    vecs[0]  = '{1'b0, 4'd0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 4'd0, 3'b000};
    vecs[1]  = '{1'b1, 4'd3, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd0, 3'b110};
    vecs[2]  = '{1'b1, 4'd6, 32'h103, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 3'b101};
    vecs[3]  = '{1'b1, 4'd7, 32'h102, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd0, 3'b101};
    vecs[4]  = '{1'b1, 4'd5, 32'h102, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 3'b110};
    vecs[5]  = '{1'b1, 4'd2, 32'h101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'd4, 3'b110};
    vecs[6]  = '{1'b1, 4'd3, 32'h102, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 4'd4, 3'b110};
    vecs[7]  = '{1'b1, 4'd8, 32'h101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 4'd6, 3'b101};
    vecs[8]  = '{1'b1, 4'd7, 32'h103, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 4'd6, 3'b101};
    vecs[9]  = '{1'b1, 4'd3, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 4'd3, 3'b010};
    vecs[10] = '{1'b1, 4'd8, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 4'd3, 3'b101};
    vecs[11] = '{1'b1, 4'd2, 32'h101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'd3, 3'b110};
    vecs[12] = '{1'b1, 4'd1, 32'h103, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 3'b110};
    vecs[13] = '{1'b0, 4'd3, 32'h102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 4'd0, 3'b010};
    vecs[14] = '{1'b1, 4'd4, 32'h101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'd3, 3'b010};

    rst_n = 1'b0;
    sdata = 32'h0;
    drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state with idle inputs
    @(negedge clk);
    #1;
    chk("rst_req_ack", req_ack, 1'b0);
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dreq", dreq, 1'b0);
    chk("rst_width", dwidth, 2'b10);
    chk("rst_exc", exc, 1'b0);
    chk("rst_ldata", ldata, 32'h0);
    chk("rst_dmon", dmon, 35'h0);

    // Single-cycle vectors; DMEM never acks here so the queue stays empty
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drv(vecs[i].req, vecs[i].cmd, vecs[i].addr, 1'b0, 2'b00, 32'h0);
      ibrk = vecs[i].ibrk;
      dbrk = vecs[i].dbrk;
      #1;
      chk($sformatf("v%0d_req_ack", i), req_ack, vecs[i].e_ack);
      chk($sformatf("v%0d_dreq", i), dreq, vecs[i].e_dreq);
      chk($sformatf("v%0d_dcmd", i), dcmd, vecs[i].e_dcmd);
      chk($sformatf("v%0d_width", i), dwidth, vecs[i].e_width);
      chk($sformatf("v%0d_exc", i), exc, vecs[i].e_exc);
      chk($sformatf("v%0d_code", i), exc_code, vecs[i].e_code);
      chk($sformatf("v%0d_dmon", i), dmon[34:32], vecs[i].e_dmon);
      chk($sformatf("v%0d_rdy", i), rdy, 1'b0);
    end

    // Pass-through of address and store data
    @(negedge clk);
    drv(1'b0, 4'd0, 32'hDEAD_BEE0, 1'b0, 2'b00, 32'h0);
    sdata = 32'h1234_5678;
    #1;
    chk("pt_addr", daddr, 32'hDEAD_BEE0);
    chk("pt_wdata", dwdata, 32'h1234_5678);
    chk("pt_dmon_addr", dmon[31:0], 32'hDEAD_BEE0);

    // Seq A: back-to-back LW, third stalls while full, in-order data
    @(negedge clk); drv(1'b1, 4'd3, 32'h100, 1'b1, 2'b00, 32'h0); #1;
    chk("a_ack1", req_ack, 1'b1);
    chk("a_busy0", busy, 1'b0);
    @(negedge clk); drv(1'b1, 4'd3, 32'h104, 1'b1, 2'b00, 32'h0); #1;
    chk("a_ack2", req_ack, 1'b1);
    chk("a_busy1", busy, 1'b1);
    @(negedge clk); drv(1'b1, 4'd3, 32'h108, 1'b1, 2'b00, 32'h0); #1;
    chk("a_full_dreq", dreq, 1'b0);
    chk("a_full_ack", req_ack, 1'b0);
    chk("a_full_dmon", dmon[34], 1'b0);
    @(negedge clk); drv(1'b1, 4'd3, 32'h108, 1'b1, 2'b01, 32'h1111_1111); #1;
    chk("a_rdy1", rdy, 1'b1);
    chk("a_ld1", ldata, 32'h1111_1111);
    chk("a_full_pop_ack", req_ack, 1'b0);
    @(negedge clk); drv(1'b1, 4'd3, 32'h108, 1'b1, 2'b01, 32'h2222_2222); #1;
    chk("a_rdy2", rdy, 1'b1);
    chk("a_ld2", ldata, 32'h2222_2222);
    chk("a_ack3", req_ack, 1'b1);
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b01, 32'h3333_3333); #1;
    chk("a_rdy3", rdy, 1'b1);
    chk("a_ld3", ldata, 32'h3333_3333);
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b00, 32'h0); #1;
    chk("a_idle_busy", busy, 1'b0);
    chk("a_idle_rdy", rdy, 1'b0);

    // Seq B: sub-word extension (data symmetric so either alignment build applies)
    @(negedge clk); drv(1'b1, 4'd1, 32'h203, 1'b1, 2'b00, 32'h0); #1;
    chk("b_lb_ack", req_ack, 1'b1);
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b01, 32'h8000_0080); #1;
    chk("b_lb_data", ldata, 32'hFFFF_FF80);
    @(negedge clk); drv(1'b1, 4'd4, 32'h203, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b01, 32'h8000_0080); #1;
    chk("b_lbu_data", ldata, 32'h0000_0080);
    @(negedge clk); drv(1'b1, 4'd2, 32'h202, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b01, 32'h8001_8001); #1;
    chk("b_lh_data", ldata, 32'hFFFF_8001);
    @(negedge clk); drv(1'b1, 4'd5, 32'h202, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b01, 32'h8001_8001); #1;
    chk("b_lhu_data", ldata, 32'h0000_8001);

    // Seq C: misaligned LH stalls behind an outstanding load
    @(negedge clk); drv(1'b1, 4'd3, 32'h100, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b1, 4'd2, 32'h101, 1'b1, 2'b00, 32'h0); #1;
    chk("c_stall_ack", req_ack, 1'b0);
    chk("c_stall_exc", exc, 1'b0);
    chk("c_stall_dreq", dreq, 1'b0);
    @(negedge clk); drv(1'b1, 4'd2, 32'h101, 1'b1, 2'b01, 32'h0); #1;
    chk("c_pop_rdy", rdy, 1'b1);
    chk("c_pop_ack", req_ack, 1'b0);
    chk("c_pop_exc", exc, 1'b0);
    @(negedge clk); drv(1'b1, 4'd2, 32'h101, 1'b1, 2'b00, 32'h0); #1;
    chk("c_exc_ack", req_ack, 1'b1);
    chk("c_exc", exc, 1'b1);
    chk("c_exc_code", exc_code, 4'd4);
    chk("c_exc_dreq", dreq, 1'b0);

    // Seq D: error on first of two loads drains the second
    @(negedge clk); drv(1'b1, 4'd3, 32'h100, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b1, 4'd3, 32'h104, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b10, 32'h0); #1;
    chk("d_err_rdy", rdy, 1'b1);
    chk("d_err_exc", exc, 1'b1);
    chk("d_err_code", exc_code, 4'd5);
    @(negedge clk); drv(1'b1, 4'd3, 32'h200, 1'b1, 2'b01, 32'h5555_5555); #1;
    chk("d_drain_rdy", rdy, 1'b0);
    chk("d_drain_exc", exc, 1'b0);
    chk("d_drain_busy", busy, 1'b1);
    chk("d_drain_dreq", dreq, 1'b0);
    chk("d_drain_ack", req_ack, 1'b0);
    @(negedge clk); drv(1'b1, 4'd8, 32'h200, 1'b1, 2'b00, 32'h0); #1;
    chk("d_after_busy", busy, 1'b0);
    chk("d_after_ack", req_ack, 1'b1);
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b10, 32'h0); #1;
    chk("d_st_err_code", exc_code, 4'd7);
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b00, 32'h0); #1;
    chk("d_st_nodrain", busy, 1'b0);

    // Seq E: data breakpoint waits for the outstanding SW
    @(negedge clk); drv(1'b1, 4'd8, 32'h100, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b1, 4'd3, 32'h200, 1'b1, 2'b00, 32'h0); dbrk = 1'b1; #1;
    chk("e_stall_ack", req_ack, 1'b0);
    chk("e_stall_exc", exc, 1'b0);
    @(negedge clk); drv(1'b1, 4'd3, 32'h200, 1'b1, 2'b01, 32'h0); dbrk = 1'b1; #1;
    chk("e_pop_rdy", rdy, 1'b1);
    chk("e_pop_ack", req_ack, 1'b0);
    @(negedge clk); drv(1'b1, 4'd3, 32'h200, 1'b1, 2'b00, 32'h0); dbrk = 1'b1; #1;
    chk("e_exc_ack", req_ack, 1'b1);
    chk("e_exc_code", exc_code, 4'd3);
    chk("e_exc_dreq", dreq, 1'b0);

    // Seq F: reset with two loads in flight discards them
    @(negedge clk); drv(1'b1, 4'd3, 32'h100, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b1, 4'd3, 32'h104, 1'b1, 2'b00, 32'h0); #1;
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b00, 32'h0); #1;
    chk("f_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("f_busy_rst", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b01, 32'h7777_7777); #1;
    chk("f_late_rdy", rdy, 1'b0);
    chk("f_late_busy", busy, 1'b0);
    @(negedge clk); drv(1'b0, 4'd0, 32'h0, 1'b0, 2'b00, 32'h0); #1;
    chk("f_after_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
